// File: rtl/oisc_rv_decoder.sv
// oisc_rv_decoder: RV32I instruction decoder for the SUBLEQ-microcoded core.
// Latches the fetched word on a Wishbone read ack. Decodes it into register
// indices, the immediate, memory-access controls and the microcode entry
// address of the emulation routine.
// Optional feature macro: DECODER_ILLEGAL_EN adds decoder_illegal, which is
// high when the instruction maps to the illegal-instruction routine.
module oisc_rv_decoder #(
    parameter int ENTRY_SHIFT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] decoder_inst,
    input  logic        decoder_renable,
    output logic [4:0]  decoder_rs1,
    output logic [4:0]  decoder_rs2,
    output logic [4:0]  decoder_rd,
    output logic [2:0]  decoder_funct3,
    output logic        decoder_funct7,
    output logic [31:0] decoder_imm,
    output logic [8:0]  decoder_pc,
    output logic        decoder_res,
    output logic        decoder_load,
    output logic        decoder_store,
    output logic [3:0]  decoder_strb,
    output logic        decoder_sign_extend,
    output logic        decoder_rtype
`ifdef DECODER_ILLEGAL_EN
    ,
    output logic        decoder_illegal
`endif
);

    // major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // microcode routine slots
    localparam logic [4:0] SL_ADD     = 5'd0;
    localparam logic [4:0] SL_SUB     = 5'd1;
    localparam logic [4:0] SL_SLL     = 5'd2;
    localparam logic [4:0] SL_SLT     = 5'd3;
    localparam logic [4:0] SL_SLTU    = 5'd4;
    localparam logic [4:0] SL_XOR     = 5'd5;
    localparam logic [4:0] SL_SRL     = 5'd6;
    localparam logic [4:0] SL_SRA     = 5'd7;
    localparam logic [4:0] SL_OR      = 5'd8;
    localparam logic [4:0] SL_AND     = 5'd9;
    localparam logic [4:0] SL_LUI     = 5'd10;
    localparam logic [4:0] SL_AUIPC   = 5'd11;
    localparam logic [4:0] SL_JAL     = 5'd12;
    localparam logic [4:0] SL_JALR    = 5'd13;
    localparam logic [4:0] SL_BEQ     = 5'd14;
    localparam logic [4:0] SL_BNE     = 5'd15;
    localparam logic [4:0] SL_BLT     = 5'd16;
    localparam logic [4:0] SL_BGE     = 5'd17;
    localparam logic [4:0] SL_BLTU    = 5'd18;
    localparam logic [4:0] SL_BGEU    = 5'd19;
    localparam logic [4:0] SL_LOAD    = 5'd20;
    localparam logic [4:0] SL_STORE   = 5'd21;
    localparam logic [4:0] SL_FENCE   = 5'd22;
    localparam logic [4:0] SL_ILLEGAL = 5'd31;

    logic [31:0] r_ir;
    logic [31:0] w_e;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic        w_f30;
    logic [4:0]  w_rd;
    logic [4:0]  w_slot;
    logic        w_load;
    logic        w_store;

    // instruction register: cleared on reset, loaded on fetch ack
    always_ff @(posedge clk) begin
        if (!reset)
            r_ir <= '0;
        else if (decoder_renable)
            r_ir <= decoder_inst;
    end

    // bypass the register in the ack cycle so rs1 is usable immediately
    assign w_e     = decoder_renable ? decoder_inst : r_ir;
    assign w_opc   = w_e[6:0];
    assign w_f3    = w_e[14:12];
    assign w_f30   = w_e[30];
    assign w_rd    = w_e[11:7];
    assign w_load  = (w_opc == OPC_LOAD);
    assign w_store = (w_opc == OPC_STORE);

    assign decoder_rs1    = w_e[19:15];
    assign decoder_rs2    = w_e[24:20];
    assign decoder_rd     = w_rd;
    assign decoder_funct3 = w_f3;
    assign decoder_funct7 = w_f30;
    assign decoder_load   = w_load;
    assign decoder_store  = w_store;
    assign decoder_rtype  = (w_opc == OPC_OP);
    assign decoder_sign_extend = w_load & ~w_f3[2];

    // immediate assembly by instruction format
    always_comb begin
        decoder_imm = '0;
        case (w_opc)
            OPC_OPIMM, OPC_LOAD, OPC_JALR:
                decoder_imm = {{20{w_e[31]}}, w_e[31:20]};
            OPC_STORE:
                decoder_imm = {{20{w_e[31]}}, w_e[31:25], w_e[11:7]};
            OPC_BRANCH:
                decoder_imm = {{19{w_e[31]}}, w_e[31], w_e[7], w_e[30:25], w_e[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                decoder_imm = {w_e[31:12], 12'b0};
            OPC_JAL:
                decoder_imm = {{11{w_e[31]}}, w_e[31], w_e[19:12], w_e[20], w_e[30:21], 1'b0};
            default:
                decoder_imm = '0;
        endcase
    end

    // routine slot selection; unknown opcode/funct3 lands on the illegal routine
    always_comb begin
        w_slot = SL_ILLEGAL;
        case (w_opc)
            OPC_OP, OPC_OPIMM: begin
                case (w_f3)
                    3'b000: w_slot = (w_f30 && w_opc == OPC_OP) ? SL_SUB : SL_ADD;
                    3'b001: w_slot = SL_SLL;
                    3'b010: w_slot = SL_SLT;
                    3'b011: w_slot = SL_SLTU;
                    3'b100: w_slot = SL_XOR;
                    3'b101: w_slot = w_f30 ? SL_SRA : SL_SRL;
                    3'b110: w_slot = SL_OR;
                    default: w_slot = SL_AND;
                endcase
            end
            OPC_LUI:   w_slot = SL_LUI;
            OPC_AUIPC: w_slot = SL_AUIPC;
            OPC_JAL:   w_slot = SL_JAL;
            OPC_JALR:  w_slot = (w_f3 == 3'b000) ? SL_JALR : SL_ILLEGAL;
            OPC_BRANCH: begin
                case (w_f3)
                    3'b000: w_slot = SL_BEQ;
                    3'b001: w_slot = SL_BNE;
                    3'b100: w_slot = SL_BLT;
                    3'b101: w_slot = SL_BGE;
                    3'b110: w_slot = SL_BLTU;
                    3'b111: w_slot = SL_BGEU;
                    default: w_slot = SL_ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                case (w_f3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_slot = SL_LOAD;
                    default: w_slot = SL_ILLEGAL;
                endcase
            end
            OPC_STORE: begin
                case (w_f3)
                    3'b000, 3'b001, 3'b010: w_slot = SL_STORE;
                    default: w_slot = SL_ILLEGAL;
                endcase
            end
            OPC_FENCE: w_slot = (w_f3 == 3'b000) ? SL_FENCE : SL_ILLEGAL;
            default:   w_slot = SL_ILLEGAL;
        endcase
    end

    assign decoder_pc = 9'(w_slot) << ENTRY_SHIFT;

    // rd write-back only for result-producing opcodes; x0 is never written
    always_comb begin
        decoder_res = 1'b0;
        case (w_opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OPIMM, OPC_LOAD:
                decoder_res = (w_rd != 5'd0);
            default:
                decoder_res = 1'b0;
        endcase
    end

    // byte-lane select from access size; full word when not a memory op
    always_comb begin
        decoder_strb = 4'b1111;
        if (w_load || w_store) begin
            case (w_f3[1:0])
                2'b00:   decoder_strb = 4'b0001;
                2'b01:   decoder_strb = 4'b0011;
                default: decoder_strb = 4'b1111;
            endcase
        end
    end

`ifdef DECODER_ILLEGAL_EN
    assign decoder_illegal = (w_slot == SL_ILLEGAL);
`endif

endmodule

// File: tb/tb_oisc_rv_decoder.sv
// Bench for oisc_rv_decoder: hand-decoded vectors are queued as expected
// results when driven and popped/compared when the outputs are sampled.
module tb_oisc_rv_decoder;

    logic        clk;
    logic        reset;
    logic [31:0] decoder_inst;
    logic        decoder_renable;
    logic [4:0]  decoder_rs1, decoder_rs2, decoder_rd;
    logic [2:0]  decoder_funct3;
    logic        decoder_funct7;
    logic [31:0] decoder_imm;
    logic [8:0]  decoder_pc;
    logic        decoder_res, decoder_load, decoder_store;
    logic [3:0]  decoder_strb;
    logic        decoder_sign_extend, decoder_rtype;
`ifdef DECODER_ILLEGAL_EN
    logic        decoder_illegal;
`endif

    oisc_rv_decoder #(.ENTRY_SHIFT(3)) dut (
        .clk                 (clk),
        .reset               (reset),
        .decoder_inst        (decoder_inst),
        .decoder_renable     (decoder_renable),
        .decoder_rs1         (decoder_rs1),
        .decoder_rs2         (decoder_rs2),
        .decoder_rd          (decoder_rd),
        .decoder_funct3      (decoder_funct3),
        .decoder_funct7      (decoder_funct7),
        .decoder_imm         (decoder_imm),
        .decoder_pc          (decoder_pc),
        .decoder_res         (decoder_res),
        .decoder_load        (decoder_load),
        .decoder_store       (decoder_store),
        .decoder_strb        (decoder_strb),
        .decoder_sign_extend (decoder_sign_extend),
        .decoder_rtype       (decoder_rtype)
`ifdef DECODER_ILLEGAL_EN
        ,
        .decoder_illegal     (decoder_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] imm;
        logic [8:0]  pc;
        logic        res, ld, st;
        logic [3:0]  strb;
        logic        sx, rt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(logic [31:0] inst, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic [2:0] f3, logic f7, logic [31:0] imm,
                                logic [8:0] pc, logic res, logic ld, logic st,
                                logic [3:0] strb, logic sx, logic rt);
        vec_t v;
        v.inst = inst; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.pc = pc; v.res = res; v.ld = ld; v.st = st; v.strb = strb;
        v.sx = sx; v.rt = rt;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // pop the oldest expectation and compare every output against it
    task automatic sample(input string tag);
        vec_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, " sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, " rs1"},   32'(decoder_rs1),         32'(e.rs1));
        chk({tag, " rs2"},   32'(decoder_rs2),         32'(e.rs2));
        chk({tag, " rd"},    32'(decoder_rd),          32'(e.rd));
        chk({tag, " f3"},    32'(decoder_funct3),      32'(e.f3));
        chk({tag, " f7"},    32'(decoder_funct7),      32'(e.f7));
        chk({tag, " imm"},   decoder_imm,              e.imm);
        chk({tag, " pc"},    32'(decoder_pc),          32'(e.pc));
        chk({tag, " res"},   32'(decoder_res),         32'(e.res));
        chk({tag, " load"},  32'(decoder_load),        32'(e.ld));
        chk({tag, " store"}, 32'(decoder_store),       32'(e.st));
        chk({tag, " strb"},  32'(decoder_strb),        32'(e.strb));
        chk({tag, " sext"},  32'(decoder_sign_extend), 32'(e.sx));
        chk({tag, " rtype"}, 32'(decoder_rtype),       32'(e.rt));
`ifdef DECODER_ILLEGAL_EN
        chk({tag, " illegal"}, 32'(decoder_illegal), 32'(e.pc == 9'd248));
`endif
    endtask

    // drive just after a rising edge and record what must appear
    task automatic drive(input logic rst, input logic ren, input logic [31:0] inst,
                         input vec_t e);
        @(posedge clk);
        #1;
        reset           = rst;
        decoder_renable = ren;
        decoder_inst    = inst;
        sb.push_back(e);
    endtask

    vec_t idle, addi;

    initial begin
        reset           = 1'b0;
        decoder_renable = 1'b0;
        decoder_inst    = 32'h0;

        idle = mk(32'h0, 0, 0, 0, 3'd0, 0, 32'h0, 9'd248, 0, 0, 0, 4'hF, 0, 0);
        addi = mk(32'h00510093, 2, 5, 1, 3'd0, 0, 32'd5, 9'd0, 1, 0, 0, 4'hF, 0, 0);

        vecs.push_back(addi);
        vecs.push_back(mk(32'h405201B3, 4, 5, 3, 3'd0, 1, 32'h0, 9'd8, 1, 0, 0, 4'hF, 0, 1));
        vecs.push_back(mk(32'h00512423, 2, 5, 8, 3'd2, 0, 32'd8, 9'd168, 0, 0, 1, 4'hF, 0, 0));
        vecs.push_back(mk(32'hFFF38303, 7, 31, 6, 3'd0, 1, 32'hFFFFFFFF, 9'd160, 1, 1, 0, 4'h1, 1, 0));
        vecs.push_back(mk(32'h123452B7, 8, 3, 5, 3'd5, 0, 32'h12345000, 9'd80, 1, 0, 0, 4'hF, 0, 0));
        vecs.push_back(mk(32'h0000006F, 0, 0, 0, 3'd0, 0, 32'h0, 9'd96, 0, 0, 0, 4'hF, 0, 0));
        vecs.push_back(mk(32'h4035D513, 11, 3, 10, 3'd5, 1, 32'd1027, 9'd56, 1, 0, 0, 4'hF, 0, 0));
        vecs.push_back(mk(32'h0024D403, 9, 2, 8, 3'd5, 0, 32'd2, 9'd160, 1, 1, 0, 4'h3, 0, 0));
        vecs.push_back(mk(32'h00000073, 0, 0, 0, 3'd0, 0, 32'h0, 9'd248, 0, 0, 0, 4'hF, 0, 0));
        vecs.push_back(mk(32'h00C100E7, 2, 12, 1, 3'd0, 0, 32'd12, 9'd104, 1, 0, 0, 4'hF, 0, 0));
        vecs.push_back(mk(32'hFE208EE3, 1, 2, 29, 3'd0, 1, 32'hFFFFFFFC, 9'd112, 0, 0, 0, 4'hF, 0, 0));

        // reset state
        drive(1'b0, 1'b0, 32'h0, idle);
        sample("reset");
        drive(1'b1, 1'b0, 32'hDEADBEEF, idle);
        sample("post_reset");

        // each vector: bypass in the ack cycle, then held after renable drops
        foreach (vecs[i]) begin
            drive(1'b1, 1'b1, vecs[i].inst, vecs[i]);
            sample($sformatf("v%0d_ack", i));
            drive(1'b1, 1'b0, 32'h00000013, vecs[i]);
            sample($sformatf("v%0d_hold", i));
        end

        // one reset edge clears the held beq
        drive(1'b0, 1'b0, 32'h00000013, vecs[vecs.size()-1]);
        sample("rst_pre");
        drive(1'b1, 1'b0, 32'h00000013, idle);
        sample("rst_clear");

        // reset with renable high: bypass still decodes, IR is cleared
        drive(1'b0, 1'b1, addi.inst, addi);
        sample("rst_bypass");
        drive(1'b1, 1'b0, 32'h00000013, idle);
        sample("rst_bypass_cleared");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
